calc_alu_ctrl: RTL
==================

// Module: calc_alu_ctrl
// PURPOSE
//  Sequencer for the 32-bit ripple-carry add/sub datapath in the UART hex calculator.
//  - Accepts one operation (ADD/SUB/MUL) from the command parser over valid/ready.
//  - Drives the external combinational datapath: dp_sub=0 -> a+b; dp_sub=1 -> a-b (datapath inverts b, c_in=1).
//  - MUL is unsigned shift-add that reuses the same adder for WIDTH cycles.
//  - Returns result and flag to the response formatter over valid/ready.
// PARAMETERS
//  WIDTH  32              operand/datapath width; must match the add/sub datapath
//  CNT_W  $clog2(WIDTH)   MUL iteration counter width (localparam)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  cmd_valid  in   1      command present
//  cmd_ready  out  1      controller can accept a command
//  cmd_op     in   2      00 ADD, 01 SUB, 10 MUL, 11 illegal
//  cmd_a      in   WIDTH  operand A (unsigned)
//  cmd_b      in   WIDTH  operand B (unsigned)
//  dp_a       out  WIDTH  datapath operand A
//  dp_b       out  WIDTH  datapath operand B
//  dp_sub     out  1      1 = subtract mode
//  dp_sum     in   WIDTH  datapath result (combinational from dp_*)
//  dp_c_out   in   1      datapath carry out
//  rsp_valid  out  1      result valid; held until rsp_ready
//  rsp_ready  in   1      consumer accepts result
//  rsp_data   out  WIDTH  ADD/SUB result, or MUL low word
//  rsp_flag   out  1      ADD: carry; SUB: borrow (=~dp_c_out); MUL: high word nonzero
//  rsp_err    out  1      illegal opcode
// BEHAVIOUR
//  - Reset values: state=IDLE, rsp_valid=0, rsp_data=0, rsp_flag=0, rsp_err=0,
//    dp_a=0, dp_b=0, dp_sub=0.
//  - cmd_ready = (state==IDLE) & ~rst. Command accepted on the edge where cmd_valid & cmd_ready.
//  - States and transitions:
//    - IDLE -> EXEC (op 00/01): latch a, b, op; dp_sub=op[0].
//    - IDLE -> MUL (op 10): acc_hi=0, acc_lo=b, mcand=a, cnt=0.
//    - IDLE -> DONE (op 11): rsp_err=1, rsp_data=0, rsp_flag=0.
//    - EXEC (1 cycle) -> DONE: rsp_data=dp_sum, rsp_flag=dp_c_out^dp_sub.
//    - MUL, one iteration per cycle:
//      - dp_a=acc_hi, dp_b=mcand, dp_sub=0.
//      - If acc_lo[0]: {acc_hi,acc_lo} <= {dp_c_out,dp_sum,acc_lo}>>1.
//      - Else: {acc_hi,acc_lo} <= {1'b0,acc_hi,acc_lo}>>1.
//      - After WIDTH iterations (cnt==WIDTH-1) -> DONE: rsp_data=acc_lo', rsp_flag=|acc_hi'.
//    - DONE: rsp_valid=1; if rsp_ready -> IDLE, rsp_valid=0 next cycle.
//  - Latency (accept edge = edge 0):
//    - ADD/SUB: rsp_valid high after edge 2.
//    - MUL: rsp_valid high after edge WIDTH+1 (33).
//    - Illegal: rsp_valid high after edge 1.
//  - rsp_data/flag/err stable while rsp_valid=1. One command in flight; no command accepted in EXEC/MUL/DONE.
//  - Arithmetic is modulo 2^WIDTH; overflow is reported only via rsp_flag.
//  - Boundaries:
//    - SUB a==b -> 0, flag 0.
//    - MUL by 0 still takes WIDTH cycles.
//    - rsp_ready held high in DONE -> exactly one transfer.
//    - cmd_valid high while busy is ignored (no drop; parser holds it).
//  - rst mid-op: immediate abort to IDLE, all outputs to reset values, partial result discarded.
// STRUCTURE
//  - calc_defs.vh (shared with parser/formatter): OP_ADD/OP_SUB/OP_MUL/OP_ILL encodings,
//    state encodings, WIDTH default.
//  - Sub-module calc_mul_seq: acc_hi/acc_lo/mcand regs and counter, start/done pulses,
//    borrows adder via dp_*. Top muxes dp_* between EXEC and calc_mul_seq.
//  - Adder/subtractor datapath stays outside; bench wires the real 32-bit add/sub block.
// TESTING
//  - ADD 0xFFFFFFFF+0x00000001 -> rsp_data=0x00000000, flag=1, rsp_valid 2 cycles after accept.
//  - SUB 0x00000005-0x00000007 -> rsp_data=0xFFFFFFFE, flag=1; SUB 0x10-0x10 -> 0x0, flag 0.
//  - MUL 0x0000FFFF*0x00010001 -> 0xFFFFFFFF, flag 0;
//    MUL 0x00010000*0x00010000 -> 0x0, flag 1; valid after 33 cycles.
//  - op=11 -> rsp_err=1, data 0 after 1 cycle; rsp_ready low 5 cycles -> outputs held stable, no new cmd_ready.
//  - Back-to-back cmd_valid held high with 3 queued cmds, rsp_ready random -> each accepted only in IDLE, order kept.
//  - rst asserted at MUL iteration 10 -> rsp_valid=0 immediately, cmd_ready=1 after release, next ADD correct.

Source files
------------

// File: rtl/calc_alu_ctrl_pkg.sv
// Shared encodings for the hex calculator ALU controller.
package calc_alu_ctrl_pkg;

    localparam int DEF_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_ILL = 2'b11
    } op_e;

    // state   | meaning
    // ST_IDLE | waiting for a command, cmd_ready high
    // ST_EXEC | single add/sub cycle through the external datapath
    // ST_MUL  | shift-add multiply in progress, datapath lent to the mul sequencer
    // ST_DONE | result latched, holding rsp_valid until rsp_ready
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_MUL  = 2'b10,
        ST_DONE = 2'b11
    } state_e;

endpackage

// File: rtl/calc_alu_ctrl_mul_seq.sv
// Unsigned shift-add multiplier that borrows the external adder through dp_*.
module calc_alu_ctrl_mul_seq
    import calc_alu_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] dp_sum_i,
    input  logic             dp_c_out_i,
    output logic [WIDTH-1:0] dp_a_o,
    output logic [WIDTH-1:0] dp_b_o,
    output logic             done_o,
    output logic [WIDTH-1:0] prod_lo_o,
    output logic             prod_hi_nz_o
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             run_q, run_d;

    // Next-state: load on start, otherwise one add-and-shift step per cycle while running.
    always_comb begin
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        mcand_d  = mcand_q;
        cnt_d    = cnt_q;
        run_d    = run_q;
        if (start_i) begin
            acc_hi_d = '0;
            acc_lo_d = b_i;
            mcand_d  = a_i;
            cnt_d    = '0;
            run_d    = 1'b1;
        end else if (run_q) begin
            if (acc_lo_q[0]) begin
                acc_hi_d = {dp_c_out_i, dp_sum_i[WIDTH-1:1]};
                acc_lo_d = {dp_sum_i[0], acc_lo_q[WIDTH-1:1]};
            end else begin
                acc_hi_d = {1'b0, acc_hi_q[WIDTH-1:1]};
                acc_lo_d = {acc_hi_q[0], acc_lo_q[WIDTH-1:1]};
            end
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
                run_d = 1'b0;
            end
        end
    end

    // Accumulator, multiplicand and iteration counter registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            mcand_q  <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
        end else begin
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            mcand_q  <= mcand_d;
            cnt_q    <= cnt_d;
            run_q    <= run_d;
        end
    end

    assign dp_a_o       = acc_hi_q;
    assign dp_b_o       = mcand_q;
    // Final product is presented combinationally so the top can latch it on the last step.
    assign done_o       = run_q && (cnt_q == CNT_LAST);
    assign prod_lo_o    = acc_lo_d;
    assign prod_hi_nz_o = |acc_hi_d;

endmodule

// File: rtl/calc_alu_ctrl.sv
// Command sequencer for the calculator add/sub datapath, with shift-add MUL.
module calc_alu_ctrl
    import calc_alu_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [1:0]       cmd_op_i,
    input  logic [WIDTH-1:0] cmd_a_i,
    input  logic [WIDTH-1:0] cmd_b_i,
    output logic [WIDTH-1:0] dp_a_o,
    output logic [WIDTH-1:0] dp_b_o,
    output logic             dp_sub_o,
    input  logic [WIDTH-1:0] dp_sum_i,
    input  logic             dp_c_out_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [WIDTH-1:0] rsp_data_o,
    output logic             rsp_flag_o,
    output logic             rsp_err_o
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sub_q, sub_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_flag_q, rsp_flag_d;
    logic             rsp_err_q, rsp_err_d;

    logic             mul_start;
    logic             mul_done;
    logic [WIDTH-1:0] mul_dp_a, mul_dp_b, mul_lo;
    logic             mul_hi_nz;

    calc_alu_ctrl_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (mul_start),
        .a_i          (cmd_a_i),
        .b_i          (cmd_b_i),
        .dp_sum_i     (dp_sum_i),
        .dp_c_out_i   (dp_c_out_i),
        .dp_a_o       (mul_dp_a),
        .dp_b_o       (mul_dp_b),
        .done_o       (mul_done),
        .prod_lo_o    (mul_lo),
        .prod_hi_nz_o (mul_hi_nz)
    );

    // Next-state and response logic.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        sub_d       = sub_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_flag_d  = rsp_flag_q;
        rsp_err_d   = rsp_err_q;
        mul_start   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i) begin
                    unique case (cmd_op_i)
                        OP_ADD, OP_SUB: begin
                            a_d     = cmd_a_i;
                            b_d     = cmd_b_i;
                            sub_d   = cmd_op_i[0];
                            state_d = ST_EXEC;
                        end
                        OP_MUL: begin
                            mul_start = 1'b1;
                            state_d   = ST_MUL;
                        end
                        default: begin
                            rsp_err_d  = 1'b1;
                            rsp_data_d = '0;
                            rsp_flag_d = 1'b0;
                            state_d    = ST_DONE;
                        end
                    endcase
                end
            end
            ST_EXEC: begin
                // Carry out inverts to borrow in subtract mode.
                rsp_data_d = dp_sum_i;
                rsp_flag_d = dp_c_out_i ^ sub_q;
                rsp_err_d  = 1'b0;
                state_d    = ST_DONE;
            end
            ST_MUL: begin
                if (mul_done) begin
                    rsp_data_d = mul_lo;
                    rsp_flag_d = mul_hi_nz;
                    rsp_err_d  = 1'b0;
                    state_d    = ST_DONE;
                end
            end
            default: begin
                if (rsp_valid_q && rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    rsp_valid_d = 1'b1;
                end
            end
        endcase
    end

    // State and response registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sub_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_flag_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sub_q       <= sub_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_flag_q  <= rsp_flag_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign cmd_ready_o = (state_q == ST_IDLE) && !rst_i;
    assign dp_a_o      = (state_q == ST_MUL) ? mul_dp_a : a_q;
    assign dp_b_o      = (state_q == ST_MUL) ? mul_dp_b : b_q;
    assign dp_sub_o    = (state_q == ST_MUL) ? 1'b0 : sub_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_flag_o  = rsp_flag_q;
    assign rsp_err_o   = rsp_err_q;

endmodule
